// File: rtl/slot_alloc_if.sv
// slot_alloc_if: requester-facing bundle for slot_alloc_ctrl.
//   alloc_req/alloc_gnt/alloc_idx : zero-latency slot allocation handshake
//   free_vld/free_idx/free_err    : slot release and bad-release pulse
//   flush/busy                    : sequenced clear request and progress
//   occ/count/full/empty          : occupancy status
// master = requester side, slave = controller side.
interface slot_alloc_if #(
  parameter int WIDTH = 8,
  parameter int PTRW  = 3
);
  logic              alloc_req;
  logic              alloc_gnt;
  logic [PTRW-1:0]   alloc_idx;
  logic              free_vld;
  logic [PTRW-1:0]   free_idx;
  logic              free_err;
  logic              flush;
  logic              busy;
  logic [WIDTH-1:0]  occ;
  logic [PTRW:0]     count;
  logic              full;
  logic              empty;

  modport master (
    output alloc_req, free_vld, free_idx, flush,
    input  alloc_gnt, alloc_idx, free_err, busy, occ, count, full, empty
  );

  modport slave (
    input  alloc_req, free_vld, free_idx, flush,
    output alloc_gnt, alloc_idx, free_err, busy, occ, count, full, empty
  );
endinterface

// File: rtl/slot_alloc_ctrl.sv
// slot_alloc_ctrl: owns a per-slot occupancy vector and hands out free slots
// with a rotating next-fit pointer; accepts frees and runs a WIDTH-cycle
// sequenced flush.
// Ports:
//   clk   - clock, all state on posedge
//   reset - synchronous active-high reset, overrides everything
//   bus   - slot_alloc_if.slave (alloc / free / flush / status signals)
module slot_alloc_ctrl #(
  parameter int WIDTH = 8,
  parameter int PTRW  = 3
) (
  input  logic         clk,
  input  logic         reset,
  slot_alloc_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] occ_q, occ_d;
  logic [PTRW:0]    count_q, count_d;
  logic [PTRW-1:0]  ptr_q, ptr_d;
  logic [PTRW-1:0]  scan_q, scan_d;
  logic             free_err_q, free_err_d;

  logic             full;
  logic             accept;
  logic             gnt;
  logic             free_hit;
  logic [PTRW-1:0]  srch_idx;

  assign full   = (count_q == (PTRW+1)'(WIDTH));
  // A flush request takes the cycle: same-cycle alloc and free are dropped.
  assign accept = (state_q == IDLE) && !bus.flush;
  assign gnt    = bus.alloc_req && !full && accept;
  assign free_hit = accept && bus.free_vld && occ_q[bus.free_idx];

  // Next-fit search: first empty slot at or after ptr, wrapping.
  // PTRW-wide addition wraps mod WIDTH for free.
  always_comb begin : search
    logic             found;
    logic [PTRW-1:0]  cand;
    srch_idx = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 0; k < WIDTH; k++) begin
      cand = ptr_q + PTRW'(k);
      if (!found && !occ_q[cand]) begin
        srch_idx = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    count_d    = count_q;
    ptr_d      = ptr_q;
    scan_d     = scan_q;
    free_err_d = accept && bus.free_vld && !occ_q[bus.free_idx];
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          state_d = FLUSH;
          scan_d  = '0;
        end else begin
          // A grant targets an empty slot and a valid free an occupied one,
          // so the two never collide.
          if (gnt) begin
            occ_d[srch_idx] = 1'b1;
            ptr_d           = srch_idx + PTRW'(1);
          end
          if (free_hit) occ_d[bus.free_idx] = 1'b0;
          count_d = count_q + (PTRW+1)'(gnt) - (PTRW+1)'(free_hit);
        end
      end
      default: begin
        occ_d[scan_q] = 1'b0;
        scan_d        = scan_q + PTRW'(1);
        count_d       = '0;
        for (int i = 0; i < WIDTH; i++) count_d = count_d + (PTRW+1)'(occ_d[i]);
        if (scan_q == PTRW'(WIDTH-1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      occ_q      <= '0;
      count_q    <= '0;
      ptr_q      <= '0;
      scan_q     <= '0;
      free_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      count_q    <= count_d;
      ptr_q      <= ptr_d;
      scan_q     <= scan_d;
      free_err_q <= free_err_d;
    end
  end

  assign bus.alloc_gnt = gnt;
  assign bus.alloc_idx = srch_idx;
  assign bus.free_err  = free_err_q;
  assign bus.busy      = (state_q == FLUSH);
  assign bus.occ       = occ_q;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = (count_q == '0);

endmodule
